openfire_fsl_fifo: RTL and testbench
====================================

// Module: openfire_fsl_fifo
// PURPOSE
//  FSL link channel: the FIFO between one FSL master port and one FSL slave port.
//  A CPU's put port (fsl_m_write/fsl_m_control/fsl_m_full) pushes tagged words in.
//  Another CPU's or peripheral's get port (fsl_s_read/fsl_s_control/fsl_s_exists) pops them.
//  Output is first-word-fall-through: the head word is valid whenever fsl_s_exists is high.
// PARAMETERS
//  DATA_WIDTH   32  payload width; stored entry is DATA_WIDTH+1 bits (control bit on top)
//  DEPTH_LOG2   4   log2 of entry count; DEPTH = 2**DEPTH_LOG2, must be >= 1
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           synchronous, active-high
//  fsl_m_write    in   1           push request from the master side
//  fsl_m_data     in   DATA_WIDTH  payload to push
//  fsl_m_control  in   1           control tag to push with the payload
//  fsl_m_full     out  1           FIFO holds DEPTH entries; pushes are dropped
//  fsl_s_read     in   1           pop request from the slave side
//  fsl_s_data     out  DATA_WIDTH  head payload; 0 when fsl_s_exists is low
//  fsl_s_control  out  1           head control tag; 0 when fsl_s_exists is low
//  fsl_s_exists   out  1           FIFO is not empty
//  fsl_overflow   out  1           sticky flag; present only under FSL_FIFO_ERR_EN
//  fsl_underflow  out  1           sticky flag; present only under FSL_FIFO_ERR_EN
// BEHAVIOUR
//  - Reset: read and write pointers = 0, count = 0, fsl_m_full = 0, fsl_s_exists = 0.
//    fsl_s_data and fsl_s_control read 0 after reset. Storage array is not reset.
//    Reset asserted mid-transfer discards all contents on that same edge.
//  - push = fsl_m_write & ~fsl_m_full.
//  - pop = fsl_s_read & fsl_s_exists.
//  - Both decisions use the registered flags from the current cycle.
//  - Push: on the edge, mem[wr_ptr] <= {fsl_m_control, fsl_m_data}; wr_ptr increments.
//  - Pop: on the edge, rd_ptr increments. The head is read asynchronously as mem[rd_ptr].
//  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH with no special case.
//  - count is DEPTH_LOG2+1 bits: +1 on push only, -1 on pop only, unchanged on both.
//  - Flags are registered: fsl_m_full = (count == DEPTH), fsl_s_exists = (count != 0).
//    Both update on the same edge as count.
//  - Latency: a word pushed at edge N is visible with fsl_s_exists=1 in the cycle after N.
//    There is no combinational write-to-read bypass.
//  - Push while full: dropped even if a pop occurs in the same cycle.
//    The writer must observe fsl_m_full, as the execute stage does for put.
//  - Pop while empty: ignored, even if a push occurs in the same cycle.
//  - Simultaneous push and pop with 0 < count < DEPTH: both occur; count and flags hold.
//  - fsl_s_read is a single-cycle strobe; each cycle it is high and exists=1 pops one word.
//  - Ordering is strict FIFO; the control bit travels with its word unchanged.
// CONFIGURATION
//  FSL_FIFO_ERR_EN defined:
//   - Adds ports fsl_overflow and fsl_underflow, both reset to 0.
//   - fsl_overflow sets on fsl_m_write & fsl_m_full.
//   - fsl_underflow sets on fsl_s_read & ~fsl_s_exists.
//   - Both flags stay set until reset.
//  FSL_FIFO_ERR_EN undefined: the ports and their logic are absent; other behaviour is identical.
// STRUCTURE
//  - Shared defines file: FSL_DATA_WIDTH default and the FSL entry layout
//    (control bit at index DATA_WIDTH).
//  - One sub-module, openfire_fsl_fifo_ram: DEPTH x (DATA_WIDTH+1) distributed RAM with
//    one synchronous write port and one asynchronous read port.
//  - Pointer, count and flag logic stay in openfire_fsl_fifo.
// TESTING  (DEPTH_LOG2=2, DEPTH=4)
//  1. Reset, then write 0xA5A5A5A5 ctl=1 for one cycle.
//     -> next cycle: exists=1, s_data=0xA5A5A5A5, s_control=1.
//     -> after one read strobe: exists=0, s_data=0.
//  2. Write 1,2,3,4 on back-to-back cycles.
//     -> full=1 after the 4th edge.
//     -> a 5th write of 5 is dropped; reads return 1,2,3,4; exists=0 after the 4th read.
//  3. Hold count=2 (values 7,8); write 9 and read in the same cycle.
//     -> count stays 2, the read returns 7, the head becomes 8.
//     -> draining returns 8 then 9.
//  4. Full FIFO; write and read asserted together.
//     -> the pop occurs, the write is dropped, full=0 next cycle.
//     -> with ERR_EN: overflow=1.
//  5. Empty FIFO; read and write 0x55 together.
//     -> the write is accepted and exists=1 next cycle with data 0x55.
//     -> with ERR_EN: underflow=1.
//  6. Run 10 fill/drain cycles of 3 words each, so both pointers wrap.
//     -> data and ctl order stay intact.
//     -> assert reset with 2 entries held: next cycle exists=0, full=0, flags=0.

Source files
------------

// File: rtl/openfire_fsl_fifo_pkg.sv
// Shared FSL definitions: default payload width and entry layout helpers.
// An FSL entry is {control, data}; the control bit sits at index DATA_WIDTH.
package openfire_fsl_fifo_pkg;

    localparam int unsigned FSL_DATA_WIDTH = 32;
    localparam int unsigned FSL_DEPTH_LOG2 = 4;

    // Stored entry width for a given payload width (payload plus control tag).
    function automatic int unsigned fsl_entry_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

    // Bit position of the control tag inside a stored entry.
    function automatic int unsigned fsl_ctl_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/openfire_fsl_fifo_ram.sv
// Distributed RAM for the FSL FIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module openfire_fsl_fifo_ram #(
    parameter int unsigned WIDTH  = 33,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the entry on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: asynchronous, so the head falls through without a cycle of latency.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/openfire_fsl_fifo.sv
// FSL link channel FIFO between one master (put) and one slave (get) port.
// First-word-fall-through output; flags are registered from the entry count.
// Optional sticky overflow/underflow flags are built when FSL_FIFO_ERR_EN is defined.
module openfire_fsl_fifo
    import openfire_fsl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FSL_DATA_WIDTH,
    parameter int unsigned DEPTH_LOG2 = FSL_DEPTH_LOG2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fsl_m_write,
    input  logic [DATA_WIDTH-1:0] fsl_m_data,
    input  logic                  fsl_m_control,
    output logic                  fsl_m_full,
    input  logic                  fsl_s_read,
    output logic [DATA_WIDTH-1:0] fsl_s_data,
    output logic                  fsl_s_control,
    output logic                  fsl_s_exists
`ifdef FSL_FIFO_ERR_EN
    ,
    output logic                  fsl_overflow,
    output logic                  fsl_underflow
`endif
);

    localparam int unsigned ENTRY_W = fsl_entry_width(DATA_WIDTH);
    localparam int unsigned CTL_BIT = fsl_ctl_bit(DATA_WIDTH);
    localparam int unsigned PTR_W   = DEPTH_LOG2;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               exists_q, exists_d;
    logic               push_c, pop_c;
    logic [ENTRY_W-1:0] wr_entry_c;
    logic [ENTRY_W-1:0] head_c;

    // Accept decisions are made against the registered flags of this cycle.
    assign push_c     = fsl_m_write & ~full_q;
    assign pop_c      = fsl_s_read & exists_q;
    assign wr_entry_c = {fsl_m_control, fsl_m_data};

    openfire_fsl_fifo_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_c)
    );

    // Next-state for pointers, occupancy count and the flags derived from it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d   = (count_d == CNT_W'(DEPTH));
        exists_d = (count_d != '0);
    end

    // State register with synchronous reset; reset drops all held entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            exists_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            exists_q <= exists_d;
        end
    end

    assign fsl_m_full    = full_q;
    assign fsl_s_exists  = exists_q;
    // Head is masked to zero while empty so stale RAM contents never leak out.
    assign fsl_s_data    = exists_q ? head_c[DATA_WIDTH-1:0] : '0;
    assign fsl_s_control = exists_q & head_c[CTL_BIT];

`ifdef FSL_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error detection: write while full, read while empty.
    always_comb begin
        overflow_d  = overflow_q | (fsl_m_write & full_q);
        underflow_d = underflow_q | (fsl_s_read & ~exists_q);
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fsl_overflow  = overflow_q;
    assign fsl_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_openfire_fsl_fifo.sv
// Self-checking bench for openfire_fsl_fifo (DEPTH_LOG2=2, DEPTH=4).
// Reference model is a queue of {control, data} entries updated once per edge.
// Error-flag checks are included when FSL_FIFO_ERR_EN is defined.
module tb_openfire_fsl_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DLOG2 = 2;
    localparam int unsigned DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          fsl_m_write;
    logic [DW-1:0] fsl_m_data;
    logic          fsl_m_control;
    logic          fsl_m_full;
    logic          fsl_s_read;
    logic [DW-1:0] fsl_s_data;
    logic          fsl_s_control;
    logic          fsl_s_exists;
`ifdef FSL_FIFO_ERR_EN
    logic          fsl_overflow;
    logic          fsl_underflow;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    logic [DW:0] q[$];
    bit          ovf_m;
    bit          unf_m;

    openfire_fsl_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DLOG2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fsl_m_write   (fsl_m_write),
        .fsl_m_data    (fsl_m_data),
        .fsl_m_control (fsl_m_control),
        .fsl_m_full    (fsl_m_full),
        .fsl_s_read    (fsl_s_read),
        .fsl_s_data    (fsl_s_data),
        .fsl_s_control (fsl_s_control),
        .fsl_s_exists  (fsl_s_exists)
`ifdef FSL_FIFO_ERR_EN
        ,
        .fsl_overflow  (fsl_overflow),
        .fsl_underflow (fsl_underflow)
`endif
    );

    always #5 clock = ~clock;

    // Expected {exists, full, control, data} derived from the model queue.
    function automatic logic [DW+2:0] exp_vec();
        if (q.size() == 0) return '0;
        return {1'b1, (q.size() == DEPTH), q[0]};
    endfunction

    function automatic logic [DW+2:0] obs_vec();
        return {fsl_s_exists, fsl_m_full, fsl_s_control, fsl_s_data};
    endfunction

    // Drive one cycle from a falling edge, update the model at the rising edge,
    // and return at the next falling edge with inputs released.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit c, input bit r);
        int sz;
        fsl_m_write   = w;
        fsl_m_data    = d;
        fsl_m_control = c;
        fsl_s_read    = r;
        @(posedge clock);
        sz = q.size();
        if (reset) begin
            q.delete();
            ovf_m = 0;
            unf_m = 0;
        end else begin
            if (w && sz == DEPTH) ovf_m = 1;
            if (r && sz == 0) unf_m = 1;
            if (r && sz > 0) void'(q.pop_front());
            if (w && sz < DEPTH) q.push_back({c, d});
        end
        @(negedge clock);
        fsl_m_write = 1'b0;
        fsl_s_read  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        reset = 1'b0;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
`ifdef FSL_FIFO_ERR_EN
        checks++;
        if ({fsl_overflow, fsl_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_err_flags got=%b want=00", {fsl_overflow, fsl_underflow});
        end
`endif
    endtask

    task automatic test_single();
        step(1, 32'hA5A5A5A5, 1, 0);
        checks++;
        if ({fsl_s_exists, fsl_s_control, fsl_s_data} !== {2'b11, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL single_head got=%b/%b/%h want=1/1/a5a5a5a5",
                     fsl_s_exists, fsl_s_control, fsl_s_data);
        end
        step(0, '0, 0, 1);
        checks++;
        if ({fsl_s_exists, fsl_s_control, fsl_s_data} !== '0) begin
            errors++;
            $display("FAIL single_drained got=%b/%b/%h want=0/0/0",
                     fsl_s_exists, fsl_s_control, fsl_s_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) step(1, DW'(i), i[0], 0);
        checks++;
        if (fsl_m_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got=%b want=1", fsl_m_full);
        end
        step(1, 32'd5, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec() || fsl_m_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_drop5 got=%h want=%h", obs_vec(), exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (fsl_s_data !== DW'(i) || fsl_s_control !== i[0]) begin
                errors++;
                $display("FAIL fill_read%0d got=%h/%b want=%h/%b",
                         i, fsl_s_data, fsl_s_control, DW'(i), i[0]);
            end
            step(0, '0, 0, 1);
        end
        checks++;
        if (fsl_s_exists !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty got=%b want=0", fsl_s_exists);
        end
    endtask

    task automatic test_simul();
        step(1, 32'd7, 0, 0);
        step(1, 32'd8, 1, 0);
        checks++;
        if (fsl_s_data !== 32'd7) begin
            errors++;
            $display("FAIL simul_pre got=%h want=7", fsl_s_data);
        end
        step(1, 32'd9, 0, 1);
        checks++;
        if ({fsl_s_exists, fsl_m_full, fsl_s_control, fsl_s_data} !== {3'b101, 32'd8}) begin
            errors++;
            $display("FAIL simul_post got=%h want=%h", obs_vec(), {3'b101, 32'd8});
        end
        step(0, '0, 0, 1);
        checks++;
        if (fsl_s_data !== 32'd9 || fsl_s_control !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain9 got=%h want=9", fsl_s_data);
        end
        step(0, '0, 0, 1);
        checks++;
        if (fsl_s_exists !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty got=%b want=0", fsl_s_exists);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) step(1, $urandom, $urandom_range(0, 1), 0);
        step(1, $urandom, 1, 1);
        checks++;
        if (fsl_m_full !== 1'b0 || obs_vec() !== exp_vec() || q.size() != 3) begin
            errors++;
            $display("FAIL full_rw got=%h want=%h", obs_vec(), exp_vec());
        end
`ifdef FSL_FIFO_ERR_EN
        checks++;
        if (fsl_overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_overflow got=%b want=1", fsl_overflow);
        end
`endif
        while (q.size() > 0) step(0, '0, 0, 1);
    endtask

    task automatic test_empty_rw();
        step(1, 32'h55, 0, 1);
        checks++;
        if ({fsl_s_exists, fsl_s_data} !== {1'b1, 32'h55}) begin
            errors++;
            $display("FAIL empty_rw got=%b/%h want=1/55", fsl_s_exists, fsl_s_data);
        end
`ifdef FSL_FIFO_ERR_EN
        checks++;
        if (fsl_underflow !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw_underflow got=%b want=1", fsl_underflow);
        end
`endif
        step(0, '0, 0, 1);
    endtask

    task automatic test_wrap();
        int bad = 0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) step(1, $urandom, $urandom_range(0, 1), 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    bad++;
                    if (bad < 5) $display("FAIL wrap_k%0d_i%0d got=%h want=%h",
                                          k, i, obs_vec(), exp_vec());
                end
                step(0, '0, 0, 1);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 99) < 45);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL random_n%0d got=%h want=%h", n, obs_vec(), exp_vec());
            end
`ifdef FSL_FIFO_ERR_EN
            checks++;
            if ({fsl_overflow, fsl_underflow} !== {ovf_m, unf_m}) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL random_err_n%0d got=%b%b want=%b%b",
                                      n, fsl_overflow, fsl_underflow, ovf_m, unf_m);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() > 0) step(0, '0, 0, 1);
        step(1, $urandom, 1, 0);
        step(1, $urandom, 0, 0);
        reset = 1'b1;
        step(0, '0, 0, 0);
        reset = 1'b0;
        checks++;
        if ({fsl_s_exists, fsl_m_full, fsl_s_control, fsl_s_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=0", obs_vec());
        end
`ifdef FSL_FIFO_ERR_EN
        checks++;
        if ({fsl_overflow, fsl_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_err got=%b%b want=00", fsl_overflow, fsl_underflow);
        end
`endif
    endtask

    initial begin
        reset         = 1'b1;
        fsl_m_write   = 1'b0;
        fsl_m_data    = '0;
        fsl_m_control = 1'b0;
        fsl_s_read    = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
